// File: rtl/tdpr_bw.sv
// -----------------------------------------------------------------------------
// tdpr_bw : parametrised true dual-port RAM with per-byte write enables.
//
// Two independent read/write ports share one clock. Each port has its own
// same-port read-during-write mode (READ_FIRST / WRITE_FIRST / NO_CHANGE).
// An optional output register stage adds one cycle of read latency. When both
// ports touch the same address and at least one of them writes, a one-cycle
// collision pulse is raised; for bytes written by both ports, port A wins.
//
// Optional feature (macro TDPR_BW_INIT_CLEAR_EN): after reset a clear engine
// zeroes the whole array, one word per cycle, holding busy high and ignoring
// both ports until done. Without the macro busy is tied low and the array
// contents are undefined until written.
//
// Ports:
//   clk            single clock for both ports
//   rst_n          asynchronous active-low reset (outputs/pipeline only)
//   en_a / en_b    port access enable
//   we_a / we_b    per-byte write enables (all zero = read)
//   addr_a/addr_b  word address
//   din_a / din_b  write data
//   dout_a/dout_b  read data (holds when no new data)
//   vld_a / vld_b  dout carries new data this cycle
//   coll           one-cycle pulse: collision on the previous access cycle
//   busy           clear engine active
// -----------------------------------------------------------------------------
module tdpr_bw #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_SIZE  = 8,
  parameter int BYTE_SIZE  = 8,
  parameter int RDW_MODE_A = 0,
  parameter int RDW_MODE_B = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_a,
  input  logic [DATA_SIZE/BYTE_SIZE-1:0] we_a,
  input  logic [ADDR_SIZE-1:0]           addr_a,
  input  logic [DATA_SIZE-1:0]           din_a,
  output logic [DATA_SIZE-1:0]           dout_a,
  output logic                           vld_a,
  input  logic                           en_b,
  input  logic [DATA_SIZE/BYTE_SIZE-1:0] we_b,
  input  logic [ADDR_SIZE-1:0]           addr_b,
  input  logic [DATA_SIZE-1:0]           din_b,
  output logic [DATA_SIZE-1:0]           dout_b,
  output logic                           vld_b,
  output logic                           coll,
  output logic                           busy
);

  localparam int NB       = DATA_SIZE / BYTE_SIZE;
  localparam int RAM_SIZE = 2 ** ADDR_SIZE;

  // Elaboration-time parameter sanity checks
  if ((DATA_SIZE % BYTE_SIZE) != 0) begin : g_bad_byte_size
    $error("tdpr_bw: DATA_SIZE must be a multiple of BYTE_SIZE");
  end
  if ((RDW_MODE_A > 2) || (RDW_MODE_B > 2)) begin : g_bad_rdw_mode
    $error("tdpr_bw: RDW_MODE_A/RDW_MODE_B must be 0, 1 or 2");
  end

  // Replace the bytes selected by we with the corresponding bytes of new_w.
  function automatic logic [DATA_SIZE-1:0] merge_bytes(
    input logic [DATA_SIZE-1:0] old_w,
    input logic [DATA_SIZE-1:0] new_w,
    input logic [NB-1:0]        we
  );
    logic [DATA_SIZE-1:0] m;
    m = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) begin
        m[i*BYTE_SIZE +: BYTE_SIZE] = new_w[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
    return m;
  endfunction

  logic [DATA_SIZE-1:0] mem_q [RAM_SIZE];

  logic                 clearing_s;
  logic [ADDR_SIZE-1:0] clr_addr_s;

`ifdef TDPR_BW_INIT_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;

  // Clear engine state and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear engine next state: walk every address once, then settle in READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
        if (cnt_q == {ADDR_SIZE{1'b1}}) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clearing_s = (state_q == ST_CLEAR);
  assign clr_addr_s = cnt_q;
  assign busy       = clearing_s;
`else
  assign clearing_s = 1'b0;
  assign clr_addr_s = '0;
  assign busy       = 1'b0;
`endif

  logic                 acc_a_s, acc_b_s;
  logic                 wr_a_s, wr_b_s;
  logic                 rdv_a_s, rdv_b_s;
  logic [DATA_SIZE-1:0] old_a_s, old_b_s;
  logic [DATA_SIZE-1:0] rdat_a_s, rdat_b_s;
  logic                 coll_d;

  // Per-port access decode and read data selection (old word or own merge).
  // A port never sees the other port's same-cycle write.
  always_comb begin
    acc_a_s = en_a & ~clearing_s;
    acc_b_s = en_b & ~clearing_s;
    wr_a_s  = acc_a_s & (|we_a);
    wr_b_s  = acc_b_s & (|we_b);
    old_a_s = mem_q[addr_a];
    old_b_s = mem_q[addr_b];
    rdv_a_s = acc_a_s & ~((RDW_MODE_A == 2) & (|we_a));
    rdv_b_s = acc_b_s & ~((RDW_MODE_B == 2) & (|we_b));
    if (RDW_MODE_A == 1) begin
      rdat_a_s = merge_bytes(old_a_s, din_a, we_a);
    end else begin
      rdat_a_s = old_a_s;
    end
    if (RDW_MODE_B == 1) begin
      rdat_b_s = merge_bytes(old_b_s, din_b, we_b);
    end else begin
      rdat_b_s = old_b_s;
    end
    coll_d = acc_a_s & acc_b_s & (addr_a == addr_b) & (wr_a_s | wr_b_s);
  end

  // Memory array write: clear engine, else port B then port A per byte so
  // that A's later non-blocking update wins on shared bytes
  always_ff @(posedge clk) begin
    if (clearing_s) begin
      mem_q[clr_addr_s] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b_s && we_b[i]) begin
          mem_q[addr_b][i*BYTE_SIZE +: BYTE_SIZE] <= din_b[i*BYTE_SIZE +: BYTE_SIZE];
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_a_s && we_a[i]) begin
          mem_q[addr_a][i*BYTE_SIZE +: BYTE_SIZE] <= din_a[i*BYTE_SIZE +: BYTE_SIZE];
        end
      end
    end
  end

  logic [DATA_SIZE-1:0] d1_a_q, d1_b_q;
  logic                 v1_a_q, v1_b_q;
  logic                 coll_q;

  // First read stage and collision flag; data holds unless a read is returned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_a_q <= '0;
      d1_b_q <= '0;
      v1_a_q <= 1'b0;
      v1_b_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      if (rdv_a_s) begin
        d1_a_q <= rdat_a_s;
      end
      if (rdv_b_s) begin
        d1_b_q <= rdat_b_s;
      end
      v1_a_q <= rdv_a_s;
      v1_b_q <= rdv_b_s;
      coll_q <= coll_d;
    end
  end

  assign coll = coll_q;

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_SIZE-1:0] d2_a_q, d2_b_q;
    logic                 v2_a_q, v2_b_q;

    // Optional output stage: only new data advances, so dout keeps holding
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2_a_q <= '0;
        d2_b_q <= '0;
        v2_a_q <= 1'b0;
        v2_b_q <= 1'b0;
      end else begin
        if (v1_a_q) begin
          d2_a_q <= d1_a_q;
        end
        if (v1_b_q) begin
          d2_b_q <= d1_b_q;
        end
        v2_a_q <= v1_a_q;
        v2_b_q <= v1_b_q;
      end
    end

    assign dout_a = d2_a_q;
    assign dout_b = d2_b_q;
    assign vld_a  = v2_a_q;
    assign vld_b  = v2_b_q;
  end else begin : g_noreg
    assign dout_a = d1_a_q;
    assign dout_b = d1_b_q;
    assign vld_a  = v1_a_q;
    assign vld_b  = v1_b_q;
  end

endmodule

// File: tb/tb_tdpr_bw.sv
// -----------------------------------------------------------------------------
// tb_tdpr_bw : scoreboard bench for tdpr_bw.
//   dut0: ADDR 8, A READ_FIRST, B WRITE_FIRST, OUT_REG 0
//   dut1: ADDR 4, A NO_CHANGE,  B READ_FIRST,  OUT_REG 1
// Stimulus pushes expected read data (with due cycle) and expected collision
// pulses into queues; a negedge monitor pops and compares whenever the DUTs
// raise vld/coll, and flags outputs that appear unexpectedly or never appear.
// Build with +define+TDPR_BW_INIT_CLEAR_EN to also cover the clear engine.
// -----------------------------------------------------------------------------
module tb_tdpr_bw;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en_a0, en_b0, vld_a0, vld_b0, coll0, busy0;
  logic [1:0] we_a0, we_b0;
  logic [7:0] addr_a0, addr_b0;
  logic [15:0] din_a0, din_b0, dout_a0, dout_b0;

  logic       en_a1, en_b1, vld_a1, vld_b1, coll1, busy1;
  logic [1:0] we_a1, we_b1;
  logic [3:0] addr_a1, addr_b1;
  logic [15:0] din_a1, din_b1, dout_a1, dout_b1;

  tdpr_bw #(.ADDR_SIZE(8), .DATA_SIZE(16), .BYTE_SIZE(8),
            .RDW_MODE_A(0), .RDW_MODE_B(1), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a0), .we_a(we_a0), .addr_a(addr_a0), .din_a(din_a0),
    .dout_a(dout_a0), .vld_a(vld_a0),
    .en_b(en_b0), .we_b(we_b0), .addr_b(addr_b0), .din_b(din_b0),
    .dout_b(dout_b0), .vld_b(vld_b0),
    .coll(coll0), .busy(busy0));

  tdpr_bw #(.ADDR_SIZE(4), .DATA_SIZE(16), .BYTE_SIZE(8),
            .RDW_MODE_A(2), .RDW_MODE_B(0), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a1), .we_a(we_a1), .addr_a(addr_a1), .din_a(din_a1),
    .dout_a(dout_a1), .vld_a(vld_a1),
    .en_b(en_b1), .we_b(we_b1), .addr_b(addr_b1), .din_b(din_b1),
    .dout_b(dout_b1), .vld_b(vld_b1),
    .coll(coll1), .busy(busy1));

  typedef struct {
    logic [15:0] data;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t  q [4][$];          // 0:a0 1:b0 2:a1 3:b1
  int    coll_exp [2][$];
  string pname [4] = '{"dout_a0", "dout_b0", "dout_a1", "dout_b1"};
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  task automatic mon(input int p, input logic v, input logic [15:0] d);
    exp_t e;
    if (v === 1'b1) begin
      checks++;
      if (q[p].size() == 0) begin
        errors++;
        $display("FAIL %s unexpected vld: got data %h at cycle %0d, required no vld", pname[p], d, cyc);
      end else begin
        e = q[p].pop_front();
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s latency: got vld at cycle %0d, required cycle %0d", pname[p], cyc, e.cyc);
        end
        if (e.chk) begin
          checks++;
          if (d !== e.data) begin
            errors++;
            $display("FAIL %s data: got %h, required %h", pname[p], d, e.data);
          end
        end
      end
    end else if (q[p].size() > 0 && q[p][0].cyc <= cyc) begin
      e = q[p].pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing vld: got none at cycle %0d, required data %h", pname[p], cyc, e.data);
    end
  endtask

  task automatic mon_coll(input int d, input logic c);
    int e;
    if (c === 1'b1) begin
      checks++;
      if (coll_exp[d].size() == 0) begin
        errors++;
        $display("FAIL coll%0d unexpected: got 1 at cycle %0d, required 0", d, cyc);
      end else begin
        e = coll_exp[d].pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL coll%0d timing: got pulse at cycle %0d, required cycle %0d", d, cyc, e);
        end
      end
    end else if (coll_exp[d].size() > 0 && coll_exp[d][0] <= cyc) begin
      e = coll_exp[d].pop_front();
      checks++;
      errors++;
      $display("FAIL coll%0d missing: got 0 at cycle %0d, required 1", d, e);
    end
  endtask

  always @(negedge clk) begin
    mon(0, vld_a0, dout_a0);
    mon(1, vld_b0, dout_b0);
    mon(2, vld_a1, dout_a1);
    mon(3, vld_b1, dout_b1);
    mon_coll(0, coll0);
    mon_coll(1, coll1);
  end

  task automatic idle();
    en_a0 = 1'b0; we_a0 = 2'b00; addr_a0 = 8'h00; din_a0 = 16'h0000;
    en_b0 = 1'b0; we_b0 = 2'b00; addr_b0 = 8'h00; din_b0 = 16'h0000;
    en_a1 = 1'b0; we_a1 = 2'b00; addr_a1 = 4'h0; din_a1 = 16'h0000;
    en_b1 = 1'b0; we_b1 = 2'b00; addr_b1 = 4'h0; din_b1 = 16'h0000;
  endtask

  // Drive one access on port p (0:a0 1:b0 2:a1 3:b1) for the next edge
  task automatic acc(input int p, input logic [1:0] we, input logic [7:0] ad, input logic [15:0] di);
    case (p)
      0: begin en_a0 = 1'b1; we_a0 = we; addr_a0 = ad; din_a0 = di; end
      1: begin en_b0 = 1'b1; we_b0 = we; addr_b0 = ad; din_b0 = di; end
      2: begin en_a1 = 1'b1; we_a1 = we; addr_a1 = ad[3:0]; din_a1 = di; end
      default: begin en_b1 = 1'b1; we_b1 = we; addr_b1 = ad[3:0]; din_b1 = di; end
    endcase
  endtask

  task automatic push(input int p, input logic [15:0] data, input bit chk);
    exp_t e;
    e.data = data;
    e.chk  = chk;
    e.cyc  = cyc + ((p >= 2) ? 2 : 1);
    q[p].push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wait_ready(input int req_cycles);
    int n;
    n = 0;
    while ((busy0 === 1'b1) && (n < 1000)) begin
      step();
      n++;
    end
    check("clear cycles dut0", n, req_cycles);
  endtask

  initial begin
    int n1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset dout_a0", dout_a0, 16'h0000);
    check("reset dout_b0", dout_b0, 16'h0000);
    check("reset vld_a1", vld_a1, 1'b0);
    check("reset dout_b1", dout_b1, 16'h0000);
    check("reset coll0", coll0, 1'b0);
    check("reset coll1", coll1, 1'b0);
    rst_n = 1'b1;

`ifdef TDPR_BW_INIT_CLEAR_EN
    // Accesses during the clear must be ignored (no vld, no write)
    acc(2, 2'b11, 8'h03, 16'hFFFF);
    acc(1, 2'b00, 8'h10, 16'h0000);
    n1 = 0;
    while ((busy1 === 1'b1) && (n1 < 1000)) begin
      step();
      n1++;
    end
    check("clear cycles dut1", n1, 16);
    wait_ready(256 - 16);
    for (int a = 0; a < 16; a++) begin
      acc(3, 2'b00, 8'(a), 16'h0000);
      push(3, 16'h0000, 1'b1);
      step();
    end
    step();
`else
    n1 = 0;
    check("busy0 tied low", busy0, 1'b0);
    check("busy1 tied low", busy1, 1'b0);
`endif

    // ---------------- dut0 ----------------
    acc(0, 2'b11, 8'h10, 16'hBEEF); push(0, 16'h0000, 1'b0); step();
    acc(1, 2'b00, 8'h10, 16'h0000); push(1, 16'hBEEF, 1'b1); step();
    acc(0, 2'b01, 8'h10, 16'h1234); push(0, 16'hBEEF, 1'b1); step();
    acc(1, 2'b00, 8'h10, 16'h0000); push(1, 16'hBE34, 1'b1); step();
    acc(0, 2'b11, 8'h20, 16'h5555); push(0, 16'h0000, 1'b0);
    acc(1, 2'b11, 8'h21, 16'h5555); push(1, 16'h5555, 1'b1); step();
    acc(0, 2'b11, 8'h20, 16'hAAAA); push(0, 16'h5555, 1'b1);
    acc(1, 2'b11, 8'h21, 16'hAAAA); push(1, 16'hAAAA, 1'b1); step();
    acc(0, 2'b00, 8'h20, 16'h0000); push(0, 16'hAAAA, 1'b1);
    acc(1, 2'b10, 8'h21, 16'h1200); push(1, 16'h12AA, 1'b1); step();
    // write-write collision: A high byte only, B both bytes
    acc(0, 2'b10, 8'h30, 16'h1111); push(0, 16'h0000, 1'b0);
    acc(1, 2'b11, 8'h30, 16'h2222); push(1, 16'h2222, 1'b1);
    coll_exp[0].push_back(cyc + 1); step();
    acc(0, 2'b00, 8'h30, 16'h0000); push(0, 16'h1122, 1'b1);
    acc(1, 2'b00, 8'h21, 16'h0000); push(1, 16'h12AA, 1'b1); step();
    // cross-port: A reads the old word while B writes it
    acc(0, 2'b00, 8'h10, 16'h0000); push(0, 16'hBE34, 1'b1);
    acc(1, 2'b11, 8'h10, 16'hCAFE); push(1, 16'hCAFE, 1'b1);
    coll_exp[0].push_back(cyc + 1); step();
    // read-read on the same address: no collision
    acc(0, 2'b00, 8'h10, 16'h0000); push(0, 16'hCAFE, 1'b1);
    acc(1, 2'b00, 8'h10, 16'h0000); push(1, 16'hCAFE, 1'b1); step();
    acc(1, 2'b00, 8'h30, 16'h0000); push(1, 16'h1122, 1'b1); step();
    step();

    // ---------------- dut1 ----------------
    acc(2, 2'b11, 8'h02, 16'h5555); step();        // NO_CHANGE: no vld
    step();
    check("nc hold after write", dout_a1, 16'h0000);
    acc(2, 2'b00, 8'h02, 16'h0000); push(2, 16'h5555, 1'b1); step();
    acc(2, 2'b11, 8'h02, 16'hAAAA); step();
    step(); step();
    check("nc hold prior read", dout_a1, 16'h5555);
    acc(2, 2'b00, 8'h02, 16'h0000); push(2, 16'hAAAA, 1'b1); step();
    acc(3, 2'b11, 8'h00, 16'h1111); push(3, 16'h0000, 1'b0); step();
    acc(3, 2'b00, 8'h00, 16'h0000); push(3, 16'h1111, 1'b1); step();
    acc(3, 2'b00, 8'h02, 16'h0000); push(3, 16'hAAAA, 1'b1); step();
    step(); step(); step();

    // Reset while two reads are in flight: no pushes, so any vld is stale
    acc(3, 2'b00, 8'h00, 16'h0000); step();
    acc(3, 2'b00, 8'h02, 16'h0000); step();
    rst_n = 1'b0;
    #1;
    check("async rst dout_b1", dout_b1, 16'h0000);
    check("async rst dout_a1", dout_a1, 16'h0000);
    check("async rst vld_b1", vld_b1, 1'b0);
    check("async rst dout_a0", dout_a0, 16'h0000);
    check("async rst dout_b0", dout_b0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(); step(); step();
`ifdef TDPR_BW_INIT_CLEAR_EN
    wait_ready(256 - 3);
    acc(3, 2'b00, 8'h02, 16'h0000); push(3, 16'h0000, 1'b1); step();
`else
    acc(3, 2'b00, 8'h02, 16'h0000); push(3, 16'hAAAA, 1'b1); step();
`endif
    repeat (4) step();

    for (int p = 0; p < 4; p++) begin
      check({pname[p], " queue drained"}, q[p].size(), 0);
    end
    check("coll0 queue drained", coll_exp[0].size(), 0);
    check("coll1 queue drained", coll_exp[1].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
